// File: rtl/spi_slave_if_pkg.sv
// spi_slave_if_pkg
//   Types and defaults shared by the SPI slave front end.
//   The frame FSM state type and the default word width live here so the
//   top-level parameter default and the FSM agree on one definition.
package spi_slave_if_pkg;

  localparam int SPI_DEF_DATA_WIDTH = 16;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_slave_if_sync_edge.sv
// spi_sync_edge
//   SYNC_STAGES-deep synchroniser for one asynchronous input, followed by a
//   delay flop used for single-cycle rise/fall strobes.
// Ports
//   clk, rst_n : system clock, asynchronous active-low reset
//   din        : asynchronous input
//   sync       : synchronised level (last stage of the chain)
//   rise, fall : one-cycle strobes on synchronised edges
// Every flop resets to RST_VAL, so an input whose idle level is 1 gives no
// spurious edge when reset is released.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   dly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {SYNC_STAGES{RST_VAL}};
      dly   <= RST_VAL;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      dly   <= chain[SYNC_STAGES-1];
    end
  end

  assign sync = chain[SYNC_STAGES-1];
  assign rise = sync & ~dly;
  assign fall = ~sync & dly;

endmodule

// File: rtl/spi_slave_if.sv
// spi_slave_if
//   SPI mode-0 slave front end (CPOL=0, CPHA=0, MSB first). Synchronises
//   SCLK/CS_N/MOSI into i_clk, deserialises DATA_WIDTH-bit words and shifts
//   i_spi_data_tx out on MISO. Several words per frame, no gap required.
// Ports
//   i_clk, i_rst_n         : system clock, asynchronous active-low reset
//   i_sclk, i_cs_n, i_mosi : SPI pins from the master (asynchronous)
//   o_miso, o_miso_oe      : slave data out and its enable (tristate built above)
//   o_spi_data_rx          : last complete received word
//   o_spi_ready            : 1-cycle pulse when o_spi_data_rx updates
//   o_spi_busy             : frame in progress
//   i_spi_data_tx          : next word to transmit
//   o_frame_err            : 1-cycle pulse when CS_N rises mid-word
//
// state     | meaning
// ST_IDLE   | no frame; SCLK ignored, MISO held 0 and undriven
// ST_ACTIVE | CS_N low; shifting on synchronised SCLK edges
module spi_slave_if
  import spi_slave_if_pkg::*;
#(
  parameter int DATA_WIDTH  = SPI_DEF_DATA_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_sclk,
  input  logic                  i_cs_n,
  input  logic                  i_mosi,
  output logic                  o_miso,
  output logic                  o_miso_oe,
  output logic [DATA_WIDTH-1:0] o_spi_data_rx,
  output logic                  o_spi_ready,
  output logic                  o_spi_busy,
  input  logic [DATA_WIDTH-1:0] i_spi_data_tx,
  output logic                  o_frame_err
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam int FL_W  = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  logic sclk_sync_unused, sclk_rise, sclk_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(i_clk), .rst_n(i_rst_n), .din(i_sclk),
    .sync(sclk_sync_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(i_clk), .rst_n(i_rst_n), .din(i_cs_n),
    .sync(cs_sync), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(i_clk), .rst_n(i_rst_n), .din(i_mosi),
    .sync(mosi_sync), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  // After reset the CS_N chain still holds its idle reset value while it
  // flushes. A CS_N that was already low would then look like a fresh falling
  // edge, so a frame may only start once CS_N has been seen high post-flush.
  logic [FL_W-1:0] flush_cnt;
  logic            cs_armed;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      flush_cnt <= '0;
      cs_armed  <= 1'b0;
    end else if (flush_cnt != FL_W'(SYNC_STAGES)) begin
      flush_cnt <= flush_cnt + 1'b1;
    end else if (cs_sync) begin
      cs_armed  <= 1'b1;
    end
  end

  spi_state_e state, state_next;
  logic       go_active, go_idle;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    go_active  = 1'b0;
    go_idle    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cs_fall && cs_armed) begin
          state_next = ST_ACTIVE;
          go_active  = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise) begin
          state_next = ST_IDLE;
          go_idle    = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-2:0] rx_shift;
  logic [DATA_WIDTH-1:0] rx_next;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  reload_pend;

  assign rx_next = {rx_shift, mosi_sync};

  // CS_N handling sits ahead of the SCLK branch so a coincident CS_N rise
  // wins and the SCLK edge of that cycle is dropped.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_shift      <= '0;
      rx_shift      <= '0;
      bit_cnt       <= '0;
      reload_pend   <= 1'b0;
      o_spi_data_rx <= '0;
      o_spi_ready   <= 1'b0;
      o_spi_busy    <= 1'b0;
      o_miso_oe     <= 1'b0;
      o_miso        <= 1'b0;
      o_frame_err   <= 1'b0;
    end else begin
      o_spi_ready <= 1'b0;
      o_frame_err <= 1'b0;
      if (go_active) begin
        tx_shift    <= i_spi_data_tx;
        bit_cnt     <= '0;
        reload_pend <= 1'b0;
        o_spi_busy  <= 1'b1;
        o_miso_oe   <= 1'b1;
      end else if (go_idle) begin
        o_frame_err <= (bit_cnt != '0);
        bit_cnt     <= '0;
        reload_pend <= 1'b0;
        o_spi_busy  <= 1'b0;
        o_miso_oe   <= 1'b0;
      end else if (state == ST_ACTIVE) begin
        if (sclk_rise) begin
          rx_shift <= rx_next[DATA_WIDTH-2:0];
          if (bit_cnt == CNT_LAST) begin
            o_spi_data_rx <= rx_next;
            o_spi_ready   <= 1'b1;
            bit_cnt       <= '0;
            reload_pend   <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        if (sclk_fall) begin
          if (reload_pend) begin
            tx_shift    <= i_spi_data_tx;
            reload_pend <= 1'b0;
          end else begin
            tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
          end
        end
      end
      o_miso <= (state == ST_ACTIVE && !go_idle) ? tx_shift[DATA_WIDTH-1] : 1'b0;
    end
  end

endmodule
